// File: rtl/multicycle_ctrl_if.sv
// Memory request handshake between the multicycle controller and the shared
// instruction/data memory port.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// RV32I multicycle control FSM: FETCH -> DECODE -> one execute phase per class.
// Define CTRL_ILLEGAL_HALT_EN to halt on unknown opcodes instead of treating them as NOPs.
module multicycle_ctrl #(
  parameter bit RESET_IDLE = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic [6:0]                opcode,
  input  logic [2:0]                funct3,
  input  logic                      funct7_5,
  input  logic                      br_eq,
  input  logic                      br_lt,
  input  logic                      br_ltu,
  multicycle_ctrl_if.master         mem,
  output logic                      pcUpdate,
  output logic                      irWrite,
  output logic                      addrSrc,
  output logic [1:0]                regSrc,
  output logic                      regWrite,
  output logic [2:0]                immedSrc,
  output logic [1:0]                aluSrcA,
  output logic [1:0]                aluSrcB,
  output logic [3:0]                aluOp,
  output logic                      retire,
  output logic                      illegal
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, ALU_R, ALU_I, LOAD, STORE,
    BRANCH, JAL, JALR, LUI, AUIPC, HALT
  } state_t;

  localparam state_t RST_STATE = RESET_IDLE ? IDLE : FETCH;

  state_t state, state_n;
  logic   mem_req, mem_we, taken;

  assign mem.mem_req = mem_req;
  assign mem.mem_we  = mem_we;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken =  br_eq;
      3'b001:  taken = ~br_eq;
      3'b100:  taken =  br_lt;
      3'b101:  taken = ~br_lt;
      3'b110:  taken =  br_ltu;
      3'b111:  taken = ~br_ltu;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RST_STATE;
    else      state <= state_n;
  end

  // Outputs are gated by rst so mem_req drops the instant reset asserts.
  always_comb begin
    state_n  = state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    pcUpdate = 1'b0;
    irWrite  = 1'b0;
    addrSrc  = 1'b0;
    regSrc   = 2'd0;
    regWrite = 1'b0;
    immedSrc = 3'd0;
    aluSrcA  = 2'd0;
    aluSrcB  = 2'd0;
    aluOp    = 4'b0000;
    retire   = 1'b0;
    illegal  = 1'b0;
    if (rst) begin
      case (state)
        IDLE: if (run) state_n = FETCH;
        FETCH: begin
          mem_req = 1'b1;
          if (mem.mem_ready) begin
            irWrite  = 1'b1;
            pcUpdate = 1'b1;
            aluSrcB  = 2'd2;
            state_n  = DECODE;
          end
        end
        DECODE: begin
          case (opcode)
            OP_R:     state_n = ALU_R;
            OP_I:     state_n = ALU_I;
            OP_LOAD:  state_n = LOAD;
            OP_STORE: state_n = STORE;
            OP_BR:    state_n = BRANCH;
            OP_JAL:   state_n = JAL;
            OP_JALR:  state_n = JALR;
            OP_LUI:   state_n = LUI;
            OP_AUIPC: state_n = AUIPC;
            default: begin
              illegal = 1'b1;
`ifdef CTRL_ILLEGAL_HALT_EN
              state_n = HALT;
`else
              retire  = 1'b1;
              state_n = FETCH;
`endif
            end
          endcase
        end
        ALU_R: begin
          aluSrcA = 2'd2; aluOp = {funct7_5, funct3};
          regSrc = 2'd1; regWrite = 1'b1; retire = 1'b1; state_n = FETCH;
        end
        ALU_I: begin
          // only the shift-right pair uses inst[30]; elsewhere it is immediate data
          aluSrcA = 2'd2; aluSrcB = 2'd1;
          aluOp = (funct3 == 3'b101) ? {funct7_5, funct3} : {1'b0, funct3};
          regSrc = 2'd1; regWrite = 1'b1; retire = 1'b1; state_n = FETCH;
        end
        LOAD, STORE: begin
          mem_req = 1'b1; addrSrc = 1'b1; aluSrcA = 2'd2; aluSrcB = 2'd1;
          mem_we   = (state == STORE);
          immedSrc = (state == STORE) ? 3'd1 : 3'd0;
          if (mem.mem_ready) begin
            regSrc   = (state == LOAD) ? 2'd2 : 2'd0;
            regWrite = (state == LOAD);
            retire   = 1'b1;
            state_n  = FETCH;
          end
        end
        BRANCH: begin
          if (taken) begin
            pcUpdate = 1'b1; aluSrcA = 2'd1; aluSrcB = 2'd1; immedSrc = 3'd2;
          end
          retire = 1'b1; state_n = FETCH;
        end
        JAL, JALR: begin
          regSrc = 2'd0; regWrite = 1'b1; pcUpdate = 1'b1; aluSrcB = 2'd1;
          aluSrcA  = (state == JAL) ? 2'd1 : 2'd2;
          immedSrc = (state == JAL) ? 3'd4 : 3'd0;
          retire = 1'b1; state_n = FETCH;
        end
        LUI, AUIPC: begin
          aluSrcA = (state == LUI) ? 2'd3 : 2'd1;
          aluSrcB = 2'd1; immedSrc = 3'd3;
          regSrc = 2'd1; regWrite = 1'b1; retire = 1'b1; state_n = FETCH;
        end
        HALT: illegal = 1'b1;
        default: state_n = RST_STATE;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: inputs change 1ns after posedge, outputs checked on negedge.
module tb_multicycle_ctrl;
  logic       clk, rst, run;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, br_eq, br_lt, br_ltu;
  logic       pcUpdate, irWrite, addrSrc, regWrite, retire, illegal;
  logic [1:0] regSrc, aluSrcA, aluSrcB;
  logic [2:0] immedSrc;
  logic [3:0] aluOp;
  int vectors = 0;
  int miscompares = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.RESET_IDLE(1'b0)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
    .mem(bus.master), .pcUpdate(pcUpdate), .irWrite(irWrite), .addrSrc(addrSrc),
    .regSrc(regSrc), .regWrite(regWrite), .immedSrc(immedSrc), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluOp(aluOp), .retire(retire), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: present inst with zero-wait ready, end inside DECODE.
  task automatic to_decode(input logic [31:0] inst);
    step();
    opcode = inst[6:0]; funct3 = inst[14:12]; funct7_5 = inst[30];
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("fetch_irWrite", {3'b0, irWrite}, 4'd1);
    step();
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0; bus.mem_ready = 1'b0;

    @(negedge clk);
    chk("rst_mem_req", {3'b0, bus.mem_req}, 4'd0);
    chk("rst_pcUpdate", {3'b0, pcUpdate}, 4'd0);
    step(); rst = 1'b1;
    @(negedge clk);
    chk("fetch_mem_req", {3'b0, bus.mem_req}, 4'd1);
    chk("fetch_addrSrc", {3'b0, addrSrc}, 4'd0);
    #1 rst = 1'b0;
    #1 chk("midfetch_rst_mem_req", {3'b0, bus.mem_req}, 4'd0);
    step(); rst = 1'b1;
    @(negedge clk);
    chk("post_rst_mem_req", {3'b0, bus.mem_req}, 4'd1);
    chk("post_rst_addrSrc", {3'b0, addrSrc}, 4'd0);

    // ADD x3,x1,x2
    to_decode(32'h002081B3);
    @(negedge clk);
    chk("decode_mem_req", {3'b0, bus.mem_req}, 4'd0);
    chk("decode_retire", {3'b0, retire}, 4'd0);
    step();
    @(negedge clk);
    chk("add_regWrite", {3'b0, regWrite}, 4'd1);
    chk("add_aluOp", aluOp, 4'b0000);
    chk("add_aluSrcA", {2'b0, aluSrcA}, 4'd2);
    chk("add_aluSrcB", {2'b0, aluSrcB}, 4'd0);
    chk("add_retire", {3'b0, retire}, 4'd1);

    // SUB x3,x1,x2
    to_decode(32'h402081B3); step();
    @(negedge clk);
    chk("sub_aluOp", aluOp, 4'b1000);

    // SRAI x1,x1,3 keeps inst[30]; ADDI x1,x0,-1024 must not
    to_decode(32'h4030D093); step();
    @(negedge clk);
    chk("srai_aluOp", aluOp, 4'b1101);
    chk("srai_aluSrcB", {2'b0, aluSrcB}, 4'd1);
    to_decode(32'hC0000093); step();
    @(negedge clk);
    chk("addi_aluOp", aluOp, 4'b0000);

    // LW x3,0(x1) with three wait cycles
    to_decode(32'h0000A183); step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lw_wait_mem_req", {3'b0, bus.mem_req}, 4'd1);
      chk("lw_wait_addrSrc", {3'b0, addrSrc}, 4'd1);
      chk("lw_wait_regWrite", {3'b0, regWrite}, 4'd0);
      step();
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("lw_rdy_mem_req", {3'b0, bus.mem_req}, 4'd1);
    chk("lw_rdy_regWrite", {3'b0, regWrite}, 4'd1);
    chk("lw_rdy_regSrc", {2'b0, regSrc}, 4'd2);
    chk("lw_rdy_retire", {3'b0, retire}, 4'd1);
    step(); bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("lw_next_addrSrc", {3'b0, addrSrc}, 4'd0);
    chk("lw_next_mem_req", {3'b0, bus.mem_req}, 4'd1);
    chk("lw_next_regWrite", {3'b0, regWrite}, 4'd0);

    // SW x2,4(x1), zero-wait
    to_decode(32'h0020A223); step();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("sw_mem_we", {3'b0, bus.mem_we}, 4'd1);
    chk("sw_immedSrc", {1'b0, immedSrc}, 4'd1);
    chk("sw_regWrite", {3'b0, regWrite}, 4'd0);
    chk("sw_retire", {3'b0, retire}, 4'd1);
    step(); bus.mem_ready = 1'b0;

    // BNE x1,x2,8: equal -> not taken, unequal -> taken
    to_decode(32'h00209463); step();
    br_eq = 1'b1;
    @(negedge clk);
    chk("bne_nt_pcUpdate", {3'b0, pcUpdate}, 4'd0);
    chk("bne_nt_retire", {3'b0, retire}, 4'd1);
    to_decode(32'h00209463); step();
    br_eq = 1'b0;
    @(negedge clk);
    chk("bne_t_pcUpdate", {3'b0, pcUpdate}, 4'd1);
    chk("bne_t_aluSrcA", {2'b0, aluSrcA}, 4'd1);
    chk("bne_t_immedSrc", {1'b0, immedSrc}, 4'd2);

    // BLTU with br_ltu=1 taken; funct3=010 never taken
    to_decode(32'h0020E463); step();
    br_ltu = 1'b1;
    @(negedge clk);
    chk("bltu_pcUpdate", {3'b0, pcUpdate}, 4'd1);
    to_decode(32'h0020A463); step();
    @(negedge clk);
    chk("br010_pcUpdate", {3'b0, pcUpdate}, 4'd0);

    // JAL x1,8
    to_decode(32'h008000EF); step();
    @(negedge clk);
    chk("jal_regWrite", {3'b0, regWrite}, 4'd1);
    chk("jal_regSrc", {2'b0, regSrc}, 4'd0);
    chk("jal_pcUpdate", {3'b0, pcUpdate}, 4'd1);
    chk("jal_immedSrc", {1'b0, immedSrc}, 4'd4);
    step();
    @(negedge clk);
    chk("jal_after_regWrite", {3'b0, regWrite}, 4'd0);

    // LUI x1,0x12345
    to_decode(32'h123450B7); step();
    @(negedge clk);
    chk("lui_aluSrcA", {2'b0, aluSrcA}, 4'd3);
    chk("lui_immedSrc", {1'b0, immedSrc}, 4'd3);

    // Unknown opcode 0x7F
    to_decode(32'h0000007F);
    @(negedge clk);
    chk("ill_decode_illegal", {3'b0, illegal}, 4'd1);
`ifdef CTRL_ILLEGAL_HALT_EN
    chk("ill_decode_retire", {3'b0, retire}, 4'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      @(negedge clk);
      chk("halt_illegal", {3'b0, illegal}, 4'd1);
      chk("halt_mem_req", {3'b0, bus.mem_req}, 4'd0);
    end
`else
    chk("ill_decode_retire", {3'b0, retire}, 4'd1);
    step();
    @(negedge clk);
    chk("ill_next_illegal", {3'b0, illegal}, 4'd0);
    chk("ill_next_mem_req", {3'b0, bus.mem_req}, 4'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
